// File: rtl/bt_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : bt_uart_receiver
//  Purpose  : 8N1 UART receiver for the Bluetooth link, with a one-byte
//             holding register, framing/overrun pulses and an error counter.
//  Revision : 1.0
// ============================================================================
module bt_uart_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fpga_rxd,
    input  logic       rx_enable,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_sync1;
    logic               r_rxdS;
    logic [1:0]         r_warm;
    logic               r_lineArmed;
    logic [c_CNT_W-1:0] r_clkCount;
    logic [2:0]         r_bitIdx;
    logic [7:0]         r_shift;
    logic               w_clearCount;
    logic               w_shiftIn;
    logic               w_loadByte;
    logic               w_frameErr;
    logic               w_overrun;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_rxdS  <= 1'b1;
        end else begin
            r_sync1 <= fpga_rxd;
            r_rxdS  <= r_sync1;
        end
    end

    // The synchronizer resets to 1, so its output is only trusted once real
    // line samples have propagated through; a line low at reset release must
    // be seen high before a start bit is accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_warm      <= 2'b00;
            r_lineArmed <= 1'b0;
        end else begin
            r_warm <= {r_warm[0], 1'b1};
            if (r_warm[1] && r_rxdS) begin
                r_lineArmed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_clearCount = 1'b0;
        w_shiftIn    = 1'b0;
        w_loadByte   = 1'b0;
        w_frameErr   = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxdS && rx_enable && r_lineArmed) begin
                    w_nextState  = S_START;
                    w_clearCount = 1'b1;
                end
            end
            S_START: begin
                if (r_clkCount == c_HALF_LAST) begin
                    w_clearCount = 1'b1;
                    w_nextState  = r_rxdS ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_clkCount == c_BIT_LAST) begin
                    w_clearCount = 1'b1;
                    w_shiftIn    = 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_clkCount == c_BIT_LAST) begin
                    w_clearCount = 1'b1;
                    if (r_rxdS) begin
                        // Holding register is free if empty or drained this cycle
                        if (!rx_valid || rx_ready) begin
                            w_loadByte = 1'b1;
                        end else begin
                            w_overrun = 1'b1;
                        end
                        w_nextState = S_IDLE;
                    end else begin
                        w_frameErr  = 1'b1;
                        w_nextState = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rxdS) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clkCount <= '0;
            r_bitIdx   <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            if (w_clearCount || r_state == S_IDLE || r_state == S_WAIT_IDLE) begin
                r_clkCount <= '0;
            end else begin
                r_clkCount <= r_clkCount + 1'b1;
            end
            if (r_state == S_IDLE) begin
                r_bitIdx <= 3'd0;
            end else if (w_shiftIn) begin
                r_bitIdx <= r_bitIdx + 3'd1;
            end
            if (w_shiftIn) begin
                r_shift <= {r_rxdS, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            err_count     <= 8'h00;
        end else begin
            framing_error <= w_frameErr;
            overrun       <= w_overrun;
            if (w_loadByte) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if ((w_frameErr || w_overrun) && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bt_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bt_uart_receiver
//  Purpose  : Self-checking bench for bt_uart_receiver at CLKS_PER_BIT = 8.
//  Revision : 1.0
// ============================================================================
module tb_bt_uart_receiver;

    localparam int N = 8;

    logic       clock = 1'b0;
    logic       resetn;
    logic       fpga_rxd;
    logic       rx_enable;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic [7:0] err_count;
    logic       busy;

    bt_uart_receiver #(.CLKS_PER_BIT(N)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .fpga_rxd      (fpga_rxd),
        .rx_enable     (rx_enable),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .framing_error (framing_error),
        .overrun       (overrun),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Observation of DUT behaviour, sampled on the falling edge.
    int         cycle = 0;
    int         startCyc = 0, vStart = 0, latency = -1, validWidth = -1;
    int         busyRises = 0, validRises = 0, feCnt = 0, ovCnt = 0;
    int         widthErr = 0, stabErr = 0;
    logic       pBusy = 1'b0, pValid = 1'b0, pFe = 1'b0, pOv = 1'b0, pAccept = 1'b0;
    logic [7:0] pData = 8'h00;
    logic [7:0] gotQ[$];

    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (busy && !pBusy) begin
            startCyc = cycle;
            busyRises++;
        end
        if (rx_valid && !pValid) begin
            latency = cycle - startCyc;
            vStart  = cycle;
            validRises++;
        end
        if (!rx_valid && pValid) validWidth = cycle - vStart;
        if (rx_valid && rx_ready) gotQ.push_back(rx_data);
        if (framing_error) feCnt++;
        if (overrun) ovCnt++;
        if ((framing_error && pFe) || (overrun && pOv)) widthErr++;
        if (pValid && !pAccept && rx_valid && rx_data !== pData) stabErr++;
        pBusy   = busy;
        pValid  = rx_valid;
        pFe     = framing_error;
        pOv     = overrun;
        pAccept = rx_valid && rx_ready;
        pData   = rx_data;
    end

    task automatic driveBit(input logic v, input int n);
        @(negedge clock);
        fpga_rxd = v;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        driveBit(1'b0, N);
        for (int i = 0; i < 8; i++) driveBit(b[i], N);
        driveBit(stopBit, N);
    endtask

    task automatic doReset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        driveBit(1'b1, 2 * N);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       ready;
        logic       expValid;
        logic [7:0] expData;
        logic [7:0] expErr;
    } vec_t;

    vec_t vecs[5];

    // Reference model state for randomized frames
    logic [7:0] expQ[$];
    logic       holdFull;
    logic [7:0] holdVal;
    int         expErr, expFe, expOv;
    int         fe0, ov0, br0, vr0;
    logic [7:0] b;
    logic       stopB, rdy;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 8'd0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 8'd0};
        vecs[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'h3C, 8'd1};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd2};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 8'h96, 8'd2};

        fpga_rxd  = 1'b1;
        rx_enable = 1'b1;
        rx_ready  = 1'b1;
        resetn    = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_framing_error", framing_error, 0);
        check("reset_overrun", overrun, 0);
        check("reset_err_count", err_count, 0);
        check("reset_busy", busy, 0);
        resetn = 1'b1;
        driveBit(1'b1, 2 * N);

        // Table-driven frames: good, held, overrun, framing error, drain+good
        ov0 = ovCnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            rx_ready = vecs[i].ready;
            sendFrame(vecs[i].data, vecs[i].stopBit);
            driveBit(1'b1, 2 * N);
            check($sformatf("vec%0d_rx_valid", i), rx_valid, vecs[i].expValid);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].expData);
            check($sformatf("vec%0d_err_count", i), err_count, vecs[i].expErr);
            if (i == 0) begin
                check("latency_start_to_valid", latency, 76);
                check("valid_pulse_width", validWidth, 1);
            end
        end
        check("table_overrun_pulses", ovCnt - ov0, 1);

        // Framing error followed by a long break
        rx_ready = 1'b1;
        doReset();
        fe0 = feCnt; vr0 = validRises; br0 = busyRises;
        sendFrame(8'h55, 1'b0);
        driveBit(1'b0, 40 * N);
        check("break_fe_pulses", feCnt - fe0, 1);
        check("break_no_valid", validRises - vr0, 0);
        check("break_err_count", err_count, 1);
        check("break_single_frame", busyRises - br0, 1);
        check("break_still_waiting", busy, 1);
        driveBit(1'b1, 2 * N);
        check("break_released_idle", busy, 0);

        // Short glitch on an idle line
        fe0 = feCnt; ov0 = ovCnt; vr0 = validRises; br0 = busyRises;
        driveBit(1'b0, 2);
        driveBit(1'b1, 2 * N);
        check("glitch_entered_start", busyRises - br0, 1);
        check("glitch_back_idle", busy, 0);
        check("glitch_no_flags", (feCnt - fe0) + (ovCnt - ov0) + (validRises - vr0), 0);
        check("glitch_err_count", err_count, 1);

        // Receiver disabled, then enabled mid-frame
        gotQ.delete();
        br0 = busyRises;
        rx_enable = 1'b0;
        sendFrame(8'hFF, 1'b1);
        driveBit(1'b1, 2 * N);
        check("disabled_no_busy", busyRises - br0, 0);
        check("disabled_nothing", gotQ.size(), 0);
        driveBit(1'b0, N);
        driveBit(1'b1, 4 * N);
        rx_enable = 1'b1;
        driveBit(1'b1, 5 * N);
        driveBit(1'b1, 2 * N);
        sendFrame(8'h7E, 1'b1);
        driveBit(1'b1, 2 * N);
        check("enable_mid_count", gotQ.size(), 1);
        if (gotQ.size() > 0) check("enable_mid_data", gotQ[0], 8'h7E);

        // Reset during data bit 4, with the line low at reset release
        driveBit(1'b0, N);
        for (int i = 0; i < 4; i++) driveBit(i[0], N);
        driveBit(1'b0, N / 2);
        resetn = 1'b0;
        @(negedge clock);
        check("midreset_busy", busy, 0);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_err_count", err_count, 0);
        check("midreset_flags", {framing_error, overrun}, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        br0 = busyRises;
        driveBit(1'b0, 3 * N);
        check("low_after_reset_no_start", busyRises - br0, 0);
        driveBit(1'b1, 2 * N);
        gotQ.delete();
        sendFrame(8'h01, 1'b1);
        driveBit(1'b1, 2 * N);
        check("post_reset_count", gotQ.size(), 1);
        if (gotQ.size() > 0) check("post_reset_data", gotQ[0], 8'h01);

        // Randomized frames against the reference model
        doReset();
        gotQ.delete();
        expQ.delete();
        holdFull = 1'b0; holdVal = 8'h00;
        expErr = 0; expFe = 0; expOv = 0;
        fe0 = feCnt; ov0 = ovCnt;
        for (int f = 0; f < 24; f++) begin
            b     = 8'($urandom);
            stopB = ($urandom_range(0, 4) != 0);
            rdy   = 1'($urandom_range(0, 1));
            @(negedge clock);
            rx_ready = rdy;
            if (rdy && holdFull) begin
                expQ.push_back(holdVal);
                holdFull = 1'b0;
            end
            if (!stopB) begin
                expFe++;
                expErr = (expErr < 255) ? expErr + 1 : 255;
            end else if (holdFull) begin
                expOv++;
                expErr = (expErr < 255) ? expErr + 1 : 255;
            end else if (rdy) begin
                expQ.push_back(b);
            end else begin
                holdFull = 1'b1;
                holdVal  = b;
            end
            sendFrame(b, stopB);
            driveBit(1'b1, 2 * N);
        end
        rx_ready = 1'b1;
        if (holdFull) expQ.push_back(holdVal);
        driveBit(1'b1, 4);
        check("rand_byte_count", gotQ.size(), expQ.size());
        for (int k = 0; k < expQ.size() && k < gotQ.size(); k++)
            check($sformatf("rand_byte%0d", k), gotQ[k], expQ[k]);
        check("rand_fe_pulses", feCnt - fe0, expFe);
        check("rand_ov_pulses", ovCnt - ov0, expOv);
        check("rand_err_count", err_count, expErr);

        // Saturation of the error counter
        for (int f = 0; f < 260; f++) begin
            sendFrame(8'($urandom), 1'b0);
            driveBit(1'b1, 2 * N);
            expErr = (expErr < 255) ? expErr + 1 : 255;
        end
        check("err_count_saturated", err_count, expErr);
        check("pulse_widths_single", widthErr, 0);
        check("rx_data_stable_while_valid", stabErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
